// File: rtl/xcvu440_reset_pkg.sv
// Package: xcvu440_reset_pkg
// Shared definitions for the reset-request controller:
//   - FSM state encoding (HOLD=0, WAIT_LOCK=1, SETTLE=2, RUN=3)
//   - bit positions inside the 4-bit cause register {sw, button, lock_loss, por}
//   - a small constant helper used to size the shared cycle counter
package xcvu440_reset_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_SETTLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_LOCK = 1;
  localparam int CAUSE_BTN  = 2;
  localparam int CAUSE_SW   = 3;

  // Value the cause register takes on reset: only the power-on bit set.
  localparam logic [3:0] CAUSE_POR_ONLY = 4'b0001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xcvu440_reset_debounce.sv
// Module: xcvu440_reset_debounce
// Synchroniser plus stable-level debouncer for an active-low push-button.
// The debounced level only changes after the synchronised input has held the
// opposite level for 2^DEBOUNCE_BITS consecutive cycles; any return to the
// current debounced level clears the count.
// Ports:
//   clock        in   reference clock
//   reset        in   synchronous, active-high
//   button_n     in   async push-button, active-low
//   btn_pressed  out  debounced button state (high = pressed), flop-derived
module xcvu440_reset_debounce
  import xcvu440_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic btn_pressed
);

  localparam logic [DEBOUNCE_BITS-1:0] STABLE_LAST = '1;

  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     btn_sync;
  logic                     level_n_q;
  logic [DEBOUNCE_BITS-1:0] stable_cnt;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which is what makes the
  // synchroniser chain shift by exactly one stage per edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= '1;
      level_n_q  <= 1'b1;
      stable_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
      if (btn_sync == level_n_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt == STABLE_LAST) begin
        level_n_q  <= btn_sync;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign btn_pressed = ~level_n_q;

endmodule

// File: rtl/xcvu440_reset_ctrl.sv
// Module: xcvu440_reset_ctrl
// Reset-request controller feeding the areset input of the clock-domain
// reset sequencer. Holds areset_out high for a minimum pulse, waits for all
// PLL/MMCM locks, requires them to stay stable for a settle time, then
// releases. Button, software request and lock loss all restart the sequence.
// Optional feature: define XCVU440_RESET_CAUSE_EN to make `cause` a sticky
// record of why the last reset happened; otherwise cause reads 4'b0000.
// Ports:
//   clock       in   free-running reference clock
//   reset       in   synchronous, active-high; forces power-on state
//   pll_locked  in   async lock indicators (NUM_PLL)
//   button_n    in   async push-button, active-low
//   sw_req      in   one-cycle software reset request
//   cause_clr   in   one-cycle clear of the cause register
//   areset_out  out  registered reset request (high = in reset)
//   rst_done    out  registered, high only in RUN
//   cause       out  {sw, button, lock_loss, por}, sticky
module xcvu440_reset_ctrl
  import xcvu440_reset_pkg::*;
#(
  parameter int NUM_PLL       = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 8,
  parameter int HOLD_CYCLES   = 64,
  parameter int SETTLE_CYCLES = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_PLL-1:0] pll_locked,
  input  logic               button_n,
  input  logic               sw_req,
  input  logic               cause_clr,
  output logic               areset_out,
  output logic               rst_done,
  output logic [3:0]         cause
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][NUM_PLL-1:0] lock_sync;
  logic                                all_locked;
  logic                                btn_pressed;
  logic                                req;
  state_t                              state, state_nx;
  logic [CNT_W-1:0]                    cnt, cnt_nx;

  always_ff @(posedge clock) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
  end

  assign all_locked = &lock_sync[SYNC_STAGES-1];

  xcvu440_reset_debounce #(
    .SYNC_STAGES   (SYNC_STAGES),
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .button_n    (button_n),
    .btn_pressed (btn_pressed)
  );

  assign req = sw_req | btn_pressed;

  // Priority: request over lock loss over counter expiry. The request
  // override is applied last so it wins regardless of the state branch.
  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (all_locked) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
        end
      end
      ST_SETTLE: begin
        if (!all_locked) begin
          state_nx = ST_WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!all_locked) begin
          state_nx = ST_HOLD;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_HOLD;
        cnt_nx   = '0;
      end
    endcase
    if (req) begin
      state_nx = ST_HOLD;
      cnt_nx   = '0;
    end
  end

  // Outputs are decoded from the next state so they switch on the same
  // edge as the state register, with no extra pipeline delay.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      areset_out <= 1'b1;
      rst_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      areset_out <= (state_nx != ST_RUN);
      rst_done   <= (state_nx == ST_RUN);
    end
  end

`ifdef XCVU440_RESET_CAUSE_EN
  logic [3:0] cause_q;
  logic [3:0] cause_set;

  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_SW]   = sw_req;
    cause_set[CAUSE_BTN]  = btn_pressed;
    cause_set[CAUSE_LOCK] = !all_locked && ((state == ST_SETTLE) || (state == ST_RUN));
  end

  // A set arriving in the same cycle as cause_clr survives the clear.
  always_ff @(posedge clock) begin
    if (reset) cause_q <= CAUSE_POR_ONLY;
    else       cause_q <= (cause_clr ? 4'b0000 : cause_q) | cause_set;
  end

  assign cause = cause_q;
`else
  logic cause_clr_unused;
  assign cause_clr_unused = cause_clr;
  assign cause            = 4'b0000;
`endif

endmodule
